param_main_memory: RTL

PARAM_MAIN_MEMORY -- requirements
Module: param_main_memory

---
 rtl/param_main_memory_pkg.sv | 15 +
 rtl/param_main_memory_if.sv | 27 ++
 rtl/param_main_memory_mem_read_port.sv | 48 ++++
 rtl/param_main_memory.sv | 94 +++++++++
 4 files changed

// File: rtl/param_main_memory_pkg.sv
// Shared defaults and controller state encoding for the parameterised main memory.
package param_main_memory_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 32768;
  localparam int DEF_NUM_CH = 21;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef enum logic [0:0] {
    MEM_INIT  = ST_INIT,
    MEM_READY = ST_READY
  } mem_state_e;
endpackage

// File: rtl/param_main_memory_if.sv
// Write port, multi-channel read port and status signals of the main memory.
interface param_main_memory_if #(
  parameter int DATA_W = param_main_memory_pkg::DEF_DATA_W,
  parameter int ADDR_W = param_main_memory_pkg::DEF_ADDR_W,
  parameter int NUM_CH = param_main_memory_pkg::DEF_NUM_CH
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ready;
  logic [NUM_CH-1:0]        rd_en;
  logic [NUM_CH*ADDR_W-1:0] rd_addr;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0]        rd_valid;
  logic                     addr_err;
  logic                     init_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_ready, rd_data, rd_valid, addr_err, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output wr_ready, rd_data, rd_valid, addr_err, init_done
  );
endinterface

// File: rtl/param_main_memory_mem_read_port.sv
// One read channel: range check, write-bypass select and registered data/valid.
module mem_read_port
  import param_main_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock_mem,
  input  logic              rst,
  input  logic              active,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err
);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              fire;
  logic              in_range;
  logic [DATA_W-1:0] next_data;

  assign fire     = active && rd_en;
  assign in_range = {1'b0, rd_addr} < DEPTH_L;
  assign addr_err = fire && !in_range;

  always_comb begin
    next_data = mem_word;
    if (!in_range)    next_data = '0;
    else if (byp_hit) next_data = byp_data;
  end

  // NOTE: rd_data holding its value is an enabled flop, not a latch; idle cycles simply skip the update.
  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= fire;
      if (fire) rd_data <= next_data;
    end
  end
endmodule

// File: rtl/param_main_memory.sv
// Main memory with power-up clear, one write port and NUM_CH concurrent read channels.
// Define MAIN_MEM_RAW_BYPASS_EN to forward same-cycle write data to colliding reads.
module param_main_memory
  import param_main_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input logic clock_mem,
  input logic rst,
  param_main_memory_if.slave bus
);
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              wr_in_range;
  logic              wr_fire;
  logic              wr_oor;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NUM_CH-1:0] rd_oor;

  assign ready         = (state == ST_READY);
  assign bus.wr_ready  = ready;
  assign bus.init_done = ready;

  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_L;
  assign wr_fire     = ready && bus.wr_en && wr_in_range;
  assign wr_oor      = ready && bus.wr_en && !wr_in_range;

  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == LAST_IDX) state <= ST_READY;
      else                      init_cnt <= init_cnt + 1'b1;
    end
  end

  // The clear sequence and user writes share the single write port.
  assign mem_we    = !rst && (!ready || wr_fire);
  assign mem_waddr = ready ? bus.wr_addr : init_cnt;
  assign mem_wdata = ready ? bus.wr_data : '0;

  // NOTE: the array has no reset branch; zeroing it is the job of the INIT sequence.
  always_ff @(posedge clock_mem) begin
    if (mem_we) mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ADDR_W-1:0] addr;
    logic              byp_hit;

    assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef MAIN_MEM_RAW_BYPASS_EN
    assign byp_hit = wr_fire && (bus.wr_addr == addr);
`else
    assign byp_hit = 1'b0;
`endif

    mem_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_port (
      .clock_mem(clock_mem),
      .rst      (rst),
      .active   (ready),
      .rd_en    (bus.rd_en[i]),
      .rd_addr  (addr),
      .mem_word (mem[addr[IDX_W-1:0]]),
      .byp_hit  (byp_hit),
      .byp_data (bus.wr_data),
      .rd_data  (bus.rd_data[i*DATA_W +: DATA_W]),
      .rd_valid (bus.rd_valid[i]),
      .addr_err (rd_oor[i])
    );
  end

  always_ff @(posedge clock_mem or posedge rst) begin
    if (rst) bus.addr_err <= 1'b0;
    else     bus.addr_err <= wr_oor || (|rd_oor);
  end
endmodule
